mem_rf_multi: RTL and testbench

Parametrised register file with NWR synchronous write ports and NRD registered read ports. It generalises the single-write/dual-read bit-wide storage element to arbitrary width, depth and port count. It adds selectable write-to-read forwarding, defined out-of-range behaviour for non-power-of-two depths, and an optional post-reset clear sweep. It sits wherever the datapath needs a small multi-ported state array, such as scoreboards or small caches.

---
 rtl/mem_rf_pkg.sv | 15 +
 rtl/mem_rf_rdport.sv | 50 +++++
 rtl/mem_rf_multi.sv | 111 +++++++++++
 tb/tb_mem_rf_multi.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_rf_pkg.sv
// Shared types and helpers for the multi-ported register file.
package mem_rf_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  function automatic logic addr_ok(input int addr, input int depth);
    return addr < depth;
  endfunction

  // Low bit of port idx inside a flat bus of w-bit fields.
  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_rf_rdport.sv
// One registered read port: forwarding mux, range check and output register.
module mem_rf_rdport
  import mem_rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int FWD   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            wr_hit,
  input  logic [DEPTH-1:0][WIDTH-1:0] wr_val,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid
);

  logic [WIDTH-1:0] rd_data_q, rd_data_d, word;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    word = '0;
    for (int e = 0; e < DEPTH; e++)
      if (rd_addr == AW'(e))
        word = (FWD != 0 && wr_hit[e]) ? wr_val[e] : mem[e];
    if (!addr_ok(int'(rd_addr), DEPTH))
      word = '0;
    rd_valid_d = run && rd_en;
    // Disabled ports keep their last data so consumers can sample late.
    rd_data_d  = rd_valid_d ? word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/mem_rf_multi.sv
// Multi-write, multi-read register file with optional forwarding and a
// post-reset clear sweep.
module mem_rf_multi
  import mem_rf_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 10,
  parameter int NWR            = 2,
  parameter int NRD            = 2,
  parameter int FWD            = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 init_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid
);

  state_e                      state_q, state_d;
  logic [AW-1:0]               clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d, wr_val;
  logic [DEPTH-1:0]            wr_hit;
  logic                        run, acc_en;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    init_busy = (state_q == CLEAR);
    run       = (state_q == RUN);
  end

  assign acc_en = run && !reset;

  // Per-entry write priority: later ports overwrite earlier ones.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int e = 0; e < DEPTH; e++)
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[lane_lo(i, AW) +: AW] == AW'(e)) begin
          wr_hit[e] = 1'b1;
          wr_val[e] = wr_data[lane_lo(i, WIDTH) +: WIDTH];
        end
  end

  always_comb begin
    mem_d = mem_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (!reset && state_q == CLEAR && clr_ptr_q == AW'(e))
        mem_d[e] = '0;
      else if (acc_en && wr_hit[e])
        mem_d[e] = wr_val[e];
    end
  end

  // Storage is not reset; contents survive reset unless the sweep runs.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    mem_rf_rdport #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AW   (AW),
      .FWD  (FWD)
    ) u_rd (
      .clk     (clk),
      .reset   (reset),
      .run     (acc_en),
      .mem     (mem_q),
      .wr_hit  (wr_hit),
      .wr_val  (wr_val),
      .rd_en   (rd_en[j]),
      .rd_addr (rd_addr[j*AW +: AW]),
      .rd_data (rd_data[j*WIDTH +: WIDTH]),
      .rd_valid(rd_valid[j])
    );
  end

endmodule

// File: tb/tb_mem_rf_multi.sv
// Directed bench: one forwarding and one non-forwarding instance share stimulus.
module tb_mem_rf_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        busy_f, busy_n;
  logic [15:0] rd_data_f, rd_data_n;
  logic [1:0]  rd_valid_f, rd_valid_n;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_mem [10];

  always #5 clk = ~clk;

  mem_rf_multi #(.WIDTH(8), .DEPTH(10), .NWR(2), .NRD(2), .FWD(1), .CLEAR_ON_RESET(1)) u_fwd (
    .clk(clk), .reset(reset), .init_busy(busy_f),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_f), .rd_valid(rd_valid_f));

  mem_rf_multi #(.WIDTH(8), .DEPTH(10), .NWR(2), .NRD(2), .FWD(0), .CLEAR_ON_RESET(1)) u_nofwd (
    .clk(clk), .reset(reset), .init_busy(busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_valid(rd_valid_n));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00; rd_en = 2'b00;
  endtask

  // Port 0 walks 0..9, port 1 walks 9..0; both instances must match the model.
  task automatic rd_check_all(input string tag);
    for (int a = 0; a < 10; a++) begin
      wr_en   = 2'b00;
      rd_en   = 2'b11;
      rd_addr = {4'(9 - a), 4'(a)};
      tick();
      chk({tag, "_f"},  {rd_valid_f, rd_data_f}, {2'b11, exp_mem[9 - a], exp_mem[a]});
      chk({tag, "_n"},  {rd_valid_n, rd_data_n}, {2'b11, exp_mem[9 - a], exp_mem[a]});
    end
    idle();
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_busy"}, {30'd0, busy_f, busy_n}, 32'd3);
      rd_en   = (k == 2) ? 2'b11 : 2'b00;
      rd_addr = 8'h33;
      tick();
      chk({tag, "_vld"}, {28'd0, rd_valid_f, rd_valid_n}, 32'd0);
    end
    idle();
    chk({tag, "_done"}, {30'd0, busy_f, busy_n}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int e = 0; e < 10; e++) exp_mem[e] = 8'h00;
    tick(); tick();
    chk("rst_busy", {30'd0, busy_f, busy_n}, 32'd3);
    chk("rst_rd",   {rd_valid_f, rd_data_f, rd_valid_n, rd_data_n}, 32'd0);

    reset = 1'b0;
    sweep_check("sweep1");
    rd_check_all("clr1");

    // Basic write then read on both ports
    wr_en = 2'b01; wr_addr = 8'h03; wr_data = 16'h00A5;
    tick();
    exp_mem[3] = 8'hA5;
    wr_en = 2'b00; rd_en = 2'b11; rd_addr = 8'h33;
    tick();
    chk("basic_f", {rd_valid_f, rd_data_f}, {2'b11, 16'hA5A5});
    chk("basic_n", {rd_valid_n, rd_data_n}, {2'b11, 16'hA5A5});

    // Hold: data stays, valid drops
    rd_en = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_f", {rd_valid_f, rd_data_f}, {2'b00, 16'hA5A5});
      chk("hold_n", {rd_valid_n, rd_data_n}, {2'b00, 16'hA5A5});
    end

    // Collision on addr 5 with same-cycle read on port 0
    wr_en = 2'b11; wr_addr = 8'h55; wr_data = 16'h2211;
    rd_en = 2'b01; rd_addr = 8'h05;
    tick();
    exp_mem[5] = 8'h22;
    chk("coll_f", {rd_valid_f, rd_data_f}, {2'b01, 16'hA522});
    chk("coll_n", {rd_valid_n, rd_data_n}, {2'b01, 16'hA500});
    wr_en = 2'b00; rd_en = 2'b11; rd_addr = 8'h55;
    tick();
    chk("coll2_f", {rd_valid_f, rd_data_f}, {2'b11, 16'h2222});
    chk("coll2_n", {rd_valid_n, rd_data_n}, {2'b11, 16'h2222});

    // Out-of-range write and read
    wr_en = 2'b01; wr_addr = 8'h0C; wr_data = 16'h00FF;
    rd_en = 2'b01; rd_addr = 8'h0C;
    tick();
    chk("oor_f", {rd_valid_f, rd_data_f}, {2'b01, 16'h2200});
    chk("oor_n", {rd_valid_n, rd_data_n}, {2'b01, 16'h2200});
    idle();
    rd_check_all("oor_all");

    // Fill every entry, then pulse reset mid-operation
    for (int e = 0; e < 5; e++) begin
      wr_en   = 2'b11;
      wr_addr = {4'(2*e + 1), 4'(2*e)};
      wr_data = {8'(8'h41 + 2*e), 8'(8'h40 + 2*e)};
      exp_mem[2*e]     = 8'(8'h40 + 2*e);
      exp_mem[2*e + 1] = 8'(8'h41 + 2*e);
      tick();
    end
    idle();
    rd_check_all("fill");

    reset = 1'b1; rd_en = 2'b11; rd_addr = 8'h12;
    tick();
    chk("mid_rst_rd", {rd_valid_f, rd_data_f, rd_valid_n, rd_data_n}, 32'd0);
    chk("mid_rst_busy", {30'd0, busy_f, busy_n}, 32'd3);
    reset = 1'b0; idle();
    for (int e = 0; e < 10; e++) exp_mem[e] = 8'h00;
    sweep_check("sweep2");
    rd_check_all("clr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
